// File: rtl/br_fifo_shared_dynamic_push_credit_sender.sv
// Credit sender: ready/valid source lanes to a credit/valid push interface.
// Option BR_FIFO_SHARED_CREDIT_SENDER_REGISTER_OUTPUTS_EN flops the push outputs.
module br_fifo_shared_dynamic_push_credit_sender #(
   parameter int NumWritePorts = 1,
   parameter int NumFifos = 2,
   parameter int Width = 1,
   parameter int MaxCredit = 3,
   localparam int PushCreditWidth = $clog2(NumWritePorts + 1),
   localparam int FifoIdWidth = (NumFifos > 2) ? $clog2(NumFifos) : 1,
   localparam int CountWidth = $clog2(MaxCredit + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NumWritePorts-1:0]             src_valid,
   output logic [NumWritePorts-1:0]             src_ready,
   input  logic [NumWritePorts*Width-1:0]       src_data,
   input  logic [NumWritePorts*FifoIdWidth-1:0] src_fifo_id,
   output logic                                 push_sender_in_reset,
   input  logic                                 push_receiver_in_reset,
   input  logic [PushCreditWidth-1:0]           push_credit,
   output logic [NumWritePorts-1:0]             push_valid,
   output logic [NumWritePorts*Width-1:0]       push_data,
   output logic [NumWritePorts*FifoIdWidth-1:0] push_fifo_id,
   input  logic [CountWidth-1:0]                credit_withhold,
   output logic [CountWidth-1:0]                credit_count,
   output logic [CountWidth-1:0]                credit_available
);

   localparam int SumWidth = CountWidth + 1;
   localparam logic [SumWidth-1:0] MaxCnt = SumWidth'(MaxCredit);

   typedef enum logic [1:0] {
      StReset,
      StWaitRx,
      StActive
   } state_e;

   state_e state_q, state_d;
   logic sir_q;
   logic [CountWidth-1:0] count_q, count_d;
   logic [CountWidth-1:0] avail;
   logic [NumWritePorts-1:0] ready, accept;
   logic [SumWidth-1:0] n_acc;
   logic [SumWidth-1:0] sum;
   logic live;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StReset;
         sir_q   <= 1'b1;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         sir_q   <= 1'b0;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StReset:  state_d = push_receiver_in_reset ? StWaitRx : StActive;
         StWaitRx: if (!push_receiver_in_reset) state_d = StActive;
         StActive: if (push_receiver_in_reset) state_d = StWaitRx;
         default:  state_d = StReset;
      endcase
   end

   // A receiver entering reset drops this cycle's pushes along with the count.
   assign live = (state_q == StActive) && !push_receiver_in_reset;

   assign avail = (count_q > credit_withhold) ?
                  (count_q - credit_withhold) : '0;

   always_comb begin
      logic [SumWidth-1:0] seen;
      seen  = '0;
      ready = '0;
      for (int i = 0; i < NumWritePorts; i++) begin
         ready[i] = live && (seen < {1'b0, avail});
         seen = seen + {{CountWidth{1'b0}}, src_valid[i]};
      end
   end

   assign accept = src_valid & ready;

   always_comb begin
      n_acc = '0;
      for (int i = 0; i < NumWritePorts; i++) begin
         n_acc = n_acc + {{CountWidth{1'b0}}, accept[i]};
      end
   end

   assign sum = {1'b0, count_q}
              + {{(SumWidth - PushCreditWidth){1'b0}}, push_credit}
              - n_acc;

   always_comb begin
      count_d = '0;
      if (live) begin
         if (sum > MaxCnt) begin
            count_d = MaxCnt[CountWidth-1:0];
         end else begin
            count_d = sum[CountWidth-1:0];
         end
      end
   end

   assign src_ready            = ready;
   assign credit_count         = count_q;
   assign credit_available     = avail;
   assign push_sender_in_reset = sir_q;

`ifdef BR_FIFO_SHARED_CREDIT_SENDER_REGISTER_OUTPUTS_EN
   logic [NumWritePorts-1:0]             pv_q;
   logic [NumWritePorts*Width-1:0]       pd_q;
   logic [NumWritePorts*FifoIdWidth-1:0] pf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pv_q <= '0;
         pd_q <= '0;
         pf_q <= '0;
      end else begin
         pv_q <= live ? accept : '0;
         pd_q <= src_data;
         pf_q <= src_fifo_id;
      end
   end

   assign push_valid   = pv_q;
   assign push_data    = pd_q;
   assign push_fifo_id = pf_q;
`else
   assign push_valid   = accept;
   assign push_data    = src_data;
   assign push_fifo_id = src_fifo_id;
`endif

endmodule
